// File: rtl/pwm_pkg.sv
// Shared PWM constants: capture FSM state encoding and default widths/timeouts.
package pwm_pkg;

    localparam int unsigned CNT_W_DEFAULT   = 20;
    localparam int unsigned TIMEOUT_DEFAULT = 1000000;

    localparam logic [1:0] StSync = 2'd0;
    localparam logic [1:0] StHigh = 2'd1;
    localparam logic [1:0] StLow  = 2'd2;

endpackage

// File: rtl/pwm_in_sync.sv
// Two-flop synchronizer plus delay flop for an asynchronous input, with edge strobes.
module pwm_in_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic s,
    output logic rise,
    output logic fall
);

    logic meta;
    logic s_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            s    <= 1'b0;
            s_d  <= 1'b0;
        end else begin
            meta <= din;
            s    <= meta;
            s_d  <= s;
        end
    end

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rising-to-rising period of an asynchronous PWM input,
// flagging loss of signal when no qualifying edge arrives within TIMEOUT cycles.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             no_signal,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};

    logic             s;
    logic             rise;
    logic             fall;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] high_tmp;

    pwm_in_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (pwm_in),
        .s     (s),
        .rise  (rise),
        .fall  (fall)
    );

    // Counter restarts on every rise, so in LOW it holds the full period so far.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= CNT_W'(1);
        end else if (cnt != CntMax) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StSync;
            high_tmp    <= '0;
            high_cnt    <= '0;
            period_cnt  <= '0;
            meas_valid  <= 1'b0;
            no_signal   <= 1'b1;
            stuck_level <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                StSync: begin
                    if (rise) begin
                        state <= StHigh;
                    end
                end
                StHigh: begin
                    // An edge in the same cycle as the timeout count takes priority.
                    if (fall) begin
                        high_tmp <= cnt;
                        state    <= StLow;
                    end else if (cnt == TimeoutVal) begin
                        state       <= StSync;
                        no_signal   <= 1'b1;
                        stuck_level <= s;
                    end
                end
                StLow: begin
                    if (rise) begin
                        period_cnt <= cnt;
                        high_cnt   <= high_tmp;
                        meas_valid <= 1'b1;
                        no_signal  <= 1'b0;
                        state      <= StHigh;
                    end else if (cnt == TimeoutVal) begin
                        state       <= StSync;
                        no_signal   <= 1'b1;
                        stuck_level <= s;
                    end
                end
                default: begin
                    state <= StSync;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus queues expected results, a monitor pops on meas_valid.
module tb_pwm_capture;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TIMEOUT = 50;

    logic             clk;
    logic             reset;
    logic             pwm_in;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             meas_valid;
    logic             no_signal;
    logic             stuck_level;

    int total;
    int bad;
    int exp_h[$];
    int exp_p[$];

    // Model of the pending (not yet published) period.
    bit pend_v;
    int pend_h;
    int pend_p;

    pwm_capture #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pwm_in      (pwm_in),
        .high_cnt    (high_cnt),
        .period_cnt  (period_cnt),
        .meas_valid  (meas_valid),
        .no_signal   (no_signal),
        .stuck_level (stuck_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic lvl, input int cycles);
        pwm_in = lvl;
        repeat (cycles) @(negedge clk);
    endtask

    // One period starting with a rise; the rise publishes the previous pending period.
    task automatic period(input int h, input int l);
        if (pend_v) begin
            exp_h.push_back(pend_h);
            exp_p.push_back(pend_p);
        end
        pend_v = 1'b1;
        pend_h = h;
        pend_p = h + l;
        drive(1'b1, h);
        drive(1'b0, l);
    endtask

    task automatic check_outputs(input string tag, input int h, input int p, input int ns,
                                 input int sl);
        check({tag, " high_cnt"}, int'(high_cnt), h);
        check({tag, " period_cnt"}, int'(period_cnt), p);
        check({tag, " no_signal"}, int'(no_signal), ns);
        check({tag, " stuck_level"}, int'(stuck_level), sl);
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (meas_valid) begin
                if (exp_h.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected meas_valid: high=%0d period=%0d, none expected",
                             high_cnt, period_cnt);
                end else begin
                    check("meas high_cnt", int'(high_cnt), exp_h.pop_front());
                    check("meas period_cnt", int'(period_cnt), exp_p.pop_front());
                end
            end
        end
    end

    initial begin
        total  = 0;
        bad    = 0;
        pend_v = 1'b0;
        pend_h = 0;
        pend_p = 0;
        reset  = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs("reset", 0, 0, 1, 0);
        check("reset meas_valid", int'(meas_valid), 0);
        reset = 1'b0;
        drive(1'b0, 4);

        // Steady 3/7 PWM
        for (int i = 0; i < 5; i++) period(3, 7);
        check("steady no_signal", int'(no_signal), 0);

        // Duty change to 8/2
        for (int i = 0; i < 3; i++) period(8, 2);

        // Stuck low: last rise publishes 8/10, then low long enough to time out
        period(3, 7);
        drive(1'b0, 53);
        pend_v = 1'b0;
        check_outputs("stuck low", 8, 10, 1, 0);

        // Resume at minimum high 1 / low 1
        for (int i = 0; i < 4; i++) period(1, 1);

        // Rise exactly at cnt == TIMEOUT: edge wins
        period(10, 40);
        period(2, 3);
        check("edge at timeout no_signal", int'(no_signal), 0);
        period(2, 3);

        // Stuck high
        if (pend_v) begin
            exp_h.push_back(pend_h);
            exp_p.push_back(pend_p);
        end
        pend_v = 1'b0;
        drive(1'b1, 60);
        check_outputs("stuck high", 2, 5, 1, 1);
        drive(1'b0, 5);

        // Reset asserted mid-LOW
        for (int i = 0; i < 3; i++) period(4, 4);
        exp_h.push_back(pend_h);
        exp_p.push_back(pend_p);
        pend_v = 1'b0;
        drive(1'b1, 4);
        drive(1'b0, 5);
        reset = 1'b1;
        #1;
        check_outputs("mid reset", 0, 0, 1, 0);
        check("mid reset meas_valid", int'(meas_valid), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 3);
        for (int i = 0; i < 3; i++) period(5, 5);
        exp_h.push_back(pend_h);
        exp_p.push_back(pend_p);
        pend_v = 1'b0;
        drive(1'b1, 3);
        drive(1'b0, 10);
        check("final no_signal", int'(no_signal), 0);
        check("scoreboard drained", exp_h.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
